// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment score readback path.
// Segment vectors are [0:6] with bit 0 = segment a, active-low.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned POINT_W = 11;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  localparam logic [0:SEG_W-1] SEG_0     = 7'b0000001;
  localparam logic [0:SEG_W-1] SEG_1     = 7'b1001111;
  localparam logic [0:SEG_W-1] SEG_2     = 7'b0010010;
  localparam logic [0:SEG_W-1] SEG_3     = 7'b0000110;
  localparam logic [0:SEG_W-1] SEG_4     = 7'b1001100;
  localparam logic [0:SEG_W-1] SEG_5     = 7'b0100100;
  localparam logic [0:SEG_W-1] SEG_6     = 7'b0100000;
  localparam logic [0:SEG_W-1] SEG_7     = 7'b0001111;
  localparam logic [0:SEG_W-1] SEG_8     = 7'b0000000;
  localparam logic [0:SEG_W-1] SEG_9     = 7'b0000100;
  localparam logic [0:SEG_W-1] SEG_BLANK = 7'b1111111;

  // Bring an arbitrary stability requirement into the representable 1..15 range.
  function automatic int unsigned clampStable(input int n);
    if (n < 1) return 1;
    if (n > int'(CNT_MAX)) return CNT_MAX;
    return $unsigned(n);
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational 7-segment to BCD decoder with per-instance blank acceptance.
module seg7_digit_decode
  import seg7_pkg::*;
#(
  parameter bit BLANK_OK = 1'b0
) (
  input  logic [0:SEG_W-1]   seg,
  output logic [DIGIT_W-1:0] bcd_c,
  output logic               illegal_c
);

  always_comb begin
    bcd_c     = '0;
    illegal_c = 1'b0;
    case (seg)
      SEG_0:     bcd_c = DIGIT_W'(0);
      SEG_1:     bcd_c = DIGIT_W'(1);
      SEG_2:     bcd_c = DIGIT_W'(2);
      SEG_3:     bcd_c = DIGIT_W'(3);
      SEG_4:     bcd_c = DIGIT_W'(4);
      SEG_5:     bcd_c = DIGIT_W'(5);
      SEG_6:     bcd_c = DIGIT_W'(6);
      SEG_7:     bcd_c = DIGIT_W'(7);
      SEG_8:     bcd_c = DIGIT_W'(8);
      SEG_9:     bcd_c = DIGIT_W'(9);
      SEG_BLANK: illegal_c = !BLANK_OK;
      default:   illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_score_reader.sv
// Three-stage segment readback: capture, decode, assemble + stability filter.
// Optional macro SEG7_READER_BLANK_EN lets blank hundreds/tens digits read as 0.
module seg7_score_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_COUNT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [0:SEG_W-1]   hundred_seg,
  input  logic [0:SEG_W-1]   ten_seg,
  input  logic [0:SEG_W-1]   current_seg,
  output logic [POINT_W-1:0] point,
  output logic               point_strobe,
  output logic               illegal_strobe,
  output logic [2:0]         illegal_digit
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(clampStable(STABLE_COUNT));
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);

`ifdef SEG7_READER_BLANK_EN
  localparam bit LEAD_BLANK_OK = 1'b1;
`else
  localparam bit LEAD_BLANK_OK = 1'b0;
`endif

  logic                s1V;
  logic [0:SEG_W-1]    s1Hund, s1Ten, s1One;
  logic                s2V;
  logic [DIGIT_W-1:0]  s2Hund, s2Ten, s2One;
  logic [2:0]          s2Illegal;
  logic [DIGIT_W-1:0]  decHund, decTen, decOne;
  logic [2:0]          decIllegal;
  logic [POINT_W-1:0]  cand, candNext, value;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic                publish, illegalHit;

  // S1: capture raw segments
  always_ff @(posedge clk) begin
    if (reset) begin
      s1V    <= 1'b0;
      s1Hund <= '0;
      s1Ten  <= '0;
      s1One  <= '0;
    end else begin
      s1V <= sample_en;
      if (sample_en) begin
        s1Hund <= hundred_seg;
        s1Ten  <= ten_seg;
        s1One  <= current_seg;
      end
    end
  end

  seg7_digit_decode #(.BLANK_OK(LEAD_BLANK_OK)) uDecHund (
    .seg(s1Hund), .bcd_c(decHund), .illegal_c(decIllegal[2]));
  seg7_digit_decode #(.BLANK_OK(LEAD_BLANK_OK)) uDecTen (
    .seg(s1Ten), .bcd_c(decTen), .illegal_c(decIllegal[1]));
  seg7_digit_decode #(.BLANK_OK(1'b0)) uDecOne (
    .seg(s1One), .bcd_c(decOne), .illegal_c(decIllegal[0]));

  // S2: registered BCD digits and illegal flags
  always_ff @(posedge clk) begin
    if (reset) begin
      s2V       <= 1'b0;
      s2Hund    <= '0;
      s2Ten     <= '0;
      s2One     <= '0;
      s2Illegal <= '0;
    end else begin
      s2V <= s1V;
      if (s1V) begin
        s2Hund    <= decHund;
        s2Ten     <= decTen;
        s2One     <= decOne;
        s2Illegal <= decIllegal;
      end
    end
  end

  // S3: digits are at most 9, so the sum tops out at 999 and fits 11 bits
  assign value = POINT_W'(s2Hund) * POINT_W'(100)
               + POINT_W'(s2Ten)  * POINT_W'(10)
               + POINT_W'(s2One);

  always_comb begin
    candNext   = cand;
    cntNext    = cnt;
    publish    = 1'b0;
    illegalHit = 1'b0;
    if (s2V) begin
      if (|s2Illegal) begin
        cntNext    = '0;
        illegalHit = 1'b1;
      end else if (value == cand) begin
        cntNext = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
      end else begin
        candNext = value;
        cntNext  = CNT_W'(1);
      end
      publish = !illegalHit && (cntNext == STABLE_CNT) && (candNext != point);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand           <= '0;
      cnt            <= '0;
      point          <= '0;
      point_strobe   <= 1'b0;
      illegal_strobe <= 1'b0;
      illegal_digit  <= '0;
    end else begin
      cand           <= candNext;
      cnt            <= cntNext;
      point_strobe   <= publish;
      illegal_strobe <= illegalHit;
      illegal_digit  <= illegalHit ? s2Illegal : 3'b000;
      if (publish) point <= candNext;
    end
  end

endmodule

// File: tb/tb_seg7_score_reader.sv
// Self-checking bench for seg7_score_reader; honours SEG7_READER_BLANK_EN when defined.
module tb_seg7_score_reader;

  localparam int STABLE = 3;

`ifdef SEG7_READER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic [0:6]  hundred_seg = '1, ten_seg = '1, current_seg = '1;
  logic [10:0] point;
  logic        point_strobe, illegal_strobe;
  logic [2:0]  illegal_digit;

  seg7_score_reader #(.STABLE_COUNT(STABLE)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .hundred_seg(hundred_seg), .ten_seg(ten_seg), .current_seg(current_seg),
    .point(point), .point_strobe(point_strobe),
    .illegal_strobe(illegal_strobe), .illegal_digit(illegal_digit));

  always #5 clk = ~clk;

  typedef struct {int pnt; int pstr; int istr; int idig;} exp_t;

  logic [0:6] segTab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic [0:6] blankPat = 7'b1111111;

  int    nAssert = 0, nFail = 0;
  int    mPoint = 0, mCand = 0, mCnt = 0;
  int    psSeen = 0, isSeen = 0;
  string curTag = "reset";
  exp_t  expQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference decode: position 0/1 are the leading digits where blank may read as 0
  function automatic int segToDigit(input logic [0:6] p, input bit leading);
    if (p == blankPat) return (leading && BLANK_EN) ? 0 : -1;
    for (int d = 0; d < 10; d++) if (segTab[d] == p) return d;
    return -1;
  endfunction

  task automatic modelSample(input logic [0:6] h, input logic [0:6] t, input logic [0:6] o,
                             output exp_t r);
    int dh, dt, dOne, v, ill;
    r = '{pnt: 0, pstr: 0, istr: 0, idig: 0};
    dh   = segToDigit(h, 1'b1);
    dt   = segToDigit(t, 1'b1);
    dOne = segToDigit(o, 1'b0);
    ill  = (dh < 0 ? 4 : 0) + (dt < 0 ? 2 : 0) + (dOne < 0 ? 1 : 0);
    if (ill != 0) begin
      mCnt   = 0;
      r.istr = 1;
      r.idig = ill;
    end else begin
      v = 100 * dh + 10 * dt + dOne;
      if (v == mCand) mCnt = (mCnt >= 15) ? 15 : mCnt + 1;
      else begin
        mCand = v;
        mCnt  = 1;
      end
      if (mCnt == STABLE && mCand != mPoint) begin
        mPoint = mCand;
        r.pstr = 1;
      end
    end
    r.pnt = mPoint;
  endtask

  // One clock: drive inputs, advance model, then compare outputs due this cycle
  task automatic tick(input bit rst, input bit en, input logic [0:6] h,
                      input logic [0:6] t, input logic [0:6] o);
    exp_t r, e;
    reset = rst; sample_en = en; hundred_seg = h; ten_seg = t; current_seg = o;
    r = '{pnt: mPoint, pstr: 0, istr: 0, idig: 0};
    if (rst) begin
      mPoint = 0; mCand = 0; mCnt = 0;
      expQ.delete();
    end else begin
      if (en) modelSample(h, t, o, r);
      expQ.push_back(r);
    end
    @(posedge clk); #1;
    if (rst) begin
      check({curTag, ".rst.point"}, 32'(point), 0);
      check({curTag, ".rst.pstrobe"}, 32'(point_strobe), 0);
      check({curTag, ".rst.istrobe"}, 32'(illegal_strobe), 0);
      check({curTag, ".rst.idigit"}, 32'(illegal_digit), 0);
      expQ.push_back('{pnt: 0, pstr: 0, istr: 0, idig: 0});
      expQ.push_back('{pnt: 0, pstr: 0, istr: 0, idig: 0});
    end else begin
      e = expQ.pop_front();
      check({curTag, ".point"}, 32'(point), e.pnt);
      check({curTag, ".pstrobe"}, 32'(point_strobe), e.pstr);
      check({curTag, ".istrobe"}, 32'(illegal_strobe), e.istr);
      if (e.istr != 0) check({curTag, ".idigit"}, 32'(illegal_digit), e.idig);
      if (point_strobe === 1'b1) psSeen++;
      if (illegal_strobe === 1'b1) isSeen++;
    end
  endtask

  task automatic sampleVal(input int v, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, segTab[v / 100], segTab[(v / 10) % 10], segTab[v % 10]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, blankPat, blankPat, blankPat);
  endtask

  initial begin
    int  v, h, t, o;
    logic [0:6] ph, pt, po;

    curTag = "reset";
    tick(1'b1, 1'b0, blankPat, blankPat, blankPat);
    idle(3);

    curTag = "t123";
    sampleVal(123, 3);
    idle(2);
    check("t123.point_n3", 32'(point), 123);
    check("t123.strobe_n3", 32'(point_strobe), 1);
    idle(2);

    curTag = "t99to100";
    psSeen = 0;
    sampleVal(99, 2);
    sampleVal(100, 3);
    idle(2);
    check("t99to100.point", 32'(point), 100);
    check("t99to100.strobe", 32'(point_strobe), 1);
    check("t99to100.pulses", 32'(psSeen), 1);
    idle(1);

    curTag = "tIllegalOnes";
    tick(1'b0, 1'b1, segTab[0], segTab[0], 7'b1111110);
    idle(2);
    check("tIllegalOnes.istrobe", 32'(illegal_strobe), 1);
    check("tIllegalOnes.idigit", 32'(illegal_digit), 1);
    check("tIllegalOnes.point", 32'(point), 100);
    sampleVal(12, 3);
    idle(2);
    check("tIllegalOnes.point012", 32'(point), 12);
    idle(1);

    curTag = "tBlank";
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, blankPat, blankPat, segTab[2]);
    idle(2);
    if (BLANK_EN) begin
      check("tBlank.point", 32'(point), 2);
      check("tBlank.pstrobe", 32'(point_strobe), 1);
    end else begin
      check("tBlank.istrobe", 32'(illegal_strobe), 1);
      check("tBlank.idigit", 32'(illegal_digit), 6);
      check("tBlank.point", 32'(point), 12);
    end
    idle(1);

    curTag = "tHold123";
    psSeen = 0;
    sampleVal(123, 10);
    idle(3);
    check("tHold123.pulses", 32'(psSeen), 1);
    check("tHold123.point", 32'(point), 123);

    curTag = "tMidReset";
    psSeen = 0; isSeen = 0;
    sampleVal(456, 3);
    idle(1);
    tick(1'b1, 1'b1, segTab[4], segTab[5], segTab[6]);
    sampleVal(456, 2);
    idle(5);
    check("tMidReset.pulses", 32'(psSeen), 0);
    check("tMidReset.ipulses", 32'(isSeen), 0);
    check("tMidReset.point", 32'(point), 0);
    sampleVal(456, 1);
    idle(2);
    check("tMidReset.point456", 32'(point), 456);

    curTag = "random";
    v = 321;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        tick(1'b1, $urandom_range(0, 1) == 1, segTab[1], segTab[2], segTab[3]);
        continue;
      end
      if ($urandom_range(0, 5) == 0) v = $urandom_range(0, 999);
      h = v / 100; t = (v / 10) % 10; o = v % 10;
      ph = segTab[h]; pt = segTab[t]; po = segTab[o];
      if (h == 0 && $urandom_range(0, 1) == 1) begin
        ph = blankPat;
        if (t == 0 && $urandom_range(0, 1) == 1) pt = blankPat;
      end
      case ($urandom_range(0, 24))
        0: ph = 7'($urandom);
        1: pt = 7'($urandom);
        2: po = 7'($urandom);
        3: po = blankPat;
        default: ;
      endcase
      tick(1'b0, $urandom_range(0, 3) != 0, ph, pt, po);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
